coprocessor0_regfile: RTL and testbench
=======================================

Name: coprocessor0_regfile

Overview:
Parametrised CP0 register file for the MIPS core. It holds BadVAddr, Count, Compare, Status, Cause and EPC using the StatusData/CauseData layouts. It takes MTC0 writes from writeback (WBToCP0Data fields), exception and ERET commits, and external interrupt lines. It produces MFC0 read data, EPC, EXL and a registered interrupt request to the pipeline; it adds a timer and a configurable interrupt-line count.

Parameters:
HW_INT_COUNT, 6, number of hardware interrupt inputs (1..6); they map to Cause.IP[2+HW_INT_COUNT-1:2], unused IP bits read 0
COUNT_DIVIDE, 2, core cycles per Count increment (>=1)
EXC_VECTOR, 32'hBFC00380, general exception entry address

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
wb_address_register  in  5  MTC0 register number
wb_address_select  in  3  MTC0 select
wb_write_enabled  in  1  MTC0 write strobe
wb_write_data  in  32  MTC0 data
read_address_register  in  5  MFC0 register number
read_address_select  in  3  MFC0 select
read_data  out  32  MFC0 data, combinational from current state
exception_valid  in  1  exception commit from writeback
exception_code  in  5  ExcCode
exception_pc  in  32  PC of the faulting instruction
exception_delay_slot  in  1  faulting instruction is in a delay slot
exception_bad_vaddr_valid  in  1  load BadVAddr
exception_bad_vaddr  in  32  faulting address
eret_valid  in  1  ERET commit
hardware_interrupt  in  HW_INT_COUNT  level interrupt lines
interrupt_pending  out  1  registered interrupt request
exception_target  out  32  constant EXC_VECTOR
epc  out  32  current EPC, the ERET target
status_exl  out  1  Status.EXL

Behaviour:
- Register map (select 0): BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14. Any other address or nonzero select reads 0, and writes to it are ignored.
- Reset values: Status=32'h0040_0000 (BEV=1). Cause, EPC, Count, Compare, BadVAddr = 0. The Count divider is 0. interrupt_pending=0.
- Writable bits:
  - Status: IM[7:0], EXL, IE. BEV and zero fields are read-only.
  - Cause: IP[1:0] (software). All other Cause bits are hardware-owned.
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr: read-only to MTC0.
- All updates take effect at the next clock edge. A read in the same cycle as a write returns the old value.
- Same-cycle priority: exception_valid > eret_valid > MTC0. The losing MTC0 or ERET is dropped entirely.
- Exception commit:
  - If EXL=0: EPC <= delay_slot ? pc-4 : pc, and Cause.BD <= delay_slot.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL <= 1, ExcCode <= exception_code.
  - BadVAddr loads only when exception_bad_vaddr_valid=1.
- ERET: EXL <= 0. Nothing else changes.
- Count and timer:
  - The divider counts 0..COUNT_DIVIDE-1. On wrap, Count increments, mod 2^32, wrapping to 0.
  - MTC0 to Count loads the value and clears the divider.
  - Cause.TI sets on the cycle Count's new value equals Compare. It is sticky and clears only on an MTC0 to Compare.
  - A Compare write in the same cycle as a match clears TI; the write wins.
- Hardware interrupts:
  - Cause.IP[7:2] are sampled every cycle from hardware_interrupt, which gives one register stage.
  - IP7 = sampled hw[5] OR TI (hw[5] exists only when HW_INT_COUNT=6).
- interrupt_pending is registered as IE & ~EXL & |(IP & IM), using current register values. It follows IP/IM/IE/EXL changes with one cycle of latency.
- Reset asserted mid-operation forces all reset values immediately (asynchronously). Nothing is retained.

Test Plan:
- Reset, then read all six registers -> Status=0x00400000, all others 0, interrupt_pending=0. Read address 15 -> 0.
- MTC0 Status=0xFFFFFFFF, then read -> 0x0040FF03. MTC0 Cause=0xFFFFFFFF -> Cause=0x00000300 (IP1:0 only).
- COUNT_DIVIDE=2, Compare=5, Status=0x00008001 -> Count reaches 5 after 10 cycles. TI=1 and Cause bit30 set; interrupt_pending=1 one cycle after IP7 is set. Write Compare -> TI=0, and interrupt_pending drops one cycle later.
- Exception code 4 at pc=0xBFC00100 with delay_slot=1, bad_vaddr=0x1233 -> EPC=0xBFC000FC, BD=1, ExcCode=4, EXL=1, BadVAddr=0x1233. A second exception with code 8 at 0x200 -> EPC unchanged, ExcCode=8. ERET -> EXL=0.
- Same cycle: exception plus MTC0 EPC=0x1234 plus ERET -> EPC from the exception, EXL=1. Next cycle MTC0 EPC=0x1234 alone -> EPC=0x1234.
- hardware_interrupt[0]=1 with IM2=1, IE=1 -> IP2 is set after 1 cycle, interrupt_pending after 2. Assert reset mid-sequence -> everything returns to reset values the same cycle.

Source files
------------

// File: rtl/coprocessor0_regfile_if.sv
// Bus between the pipeline and the CP0 register file.
// Groups the MTC0 write port, MFC0 read port, exception/ERET commit,
// hardware interrupt lines and the CP0 status outputs.
// slave  : the register file (consumes commits, drives read data/status)
// master : the pipeline side (drives commits, consumes read data/status)
interface coprocessor0_regfile_if #(
    parameter int unsigned HW_INT_COUNT = 6
);
    logic [4:0]              wb_address_register;
    logic [2:0]              wb_address_select;
    logic                    wb_write_enabled;
    logic [31:0]             wb_write_data;
    logic [4:0]              read_address_register;
    logic [2:0]              read_address_select;
    logic [31:0]             read_data;
    logic                    exception_valid;
    logic [4:0]              exception_code;
    logic [31:0]             exception_pc;
    logic                    exception_delay_slot;
    logic                    exception_bad_vaddr_valid;
    logic [31:0]             exception_bad_vaddr;
    logic                    eret_valid;
    logic [HW_INT_COUNT-1:0] hardware_interrupt;
    logic                    interrupt_pending;
    logic [31:0]             exception_target;
    logic [31:0]             epc;
    logic                    status_exl;

    modport slave (
        input  wb_address_register, wb_address_select, wb_write_enabled, wb_write_data,
        input  read_address_register, read_address_select,
        input  exception_valid, exception_code, exception_pc, exception_delay_slot,
        input  exception_bad_vaddr_valid, exception_bad_vaddr, eret_valid,
        input  hardware_interrupt,
        output read_data, interrupt_pending, exception_target, epc, status_exl
    );

    modport master (
        output wb_address_register, wb_address_select, wb_write_enabled, wb_write_data,
        output read_address_register, read_address_select,
        output exception_valid, exception_code, exception_pc, exception_delay_slot,
        output exception_bad_vaddr_valid, exception_bad_vaddr, eret_valid,
        output hardware_interrupt,
        input  read_data, interrupt_pending, exception_target, epc, status_exl
    );
endinterface

// File: rtl/coprocessor0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Ports:
//   clock, reset : core clock, asynchronous active-high reset
//   bus (slave)  : MTC0 write, MFC0 read (combinational), exception/ERET
//                  commit, hardware interrupt lines, registered interrupt
//                  request, EPC, Status.EXL and the exception vector.
module coprocessor0_regfile #(
    parameter int unsigned HW_INT_COUNT = 6,
    parameter int unsigned COUNT_DIVIDE = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic                   clock,
    input  logic                   reset,
    coprocessor0_regfile_if.slave  bus
);
    localparam int unsigned DIV_W = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    typedef struct packed {
        logic [3:0] cu;
        logic [4:0] rsvd0;
        logic       bev;
        logic [5:0] rsvd1;
        logic [7:0] im;
        logic [5:0] rsvd2;
        logic       exl;
        logic       ie;
    } status_data_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsvd0;
        logic [7:0]  ip;
        logic        rsvd1;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd2;
    } cause_data_t;

    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q,    count_d;
    logic [31:0]      compare_q,  compare_d;
    logic [31:0]      epc_q,      epc_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [7:0]       im_q,       im_d;
    logic             exl_q,      exl_d;
    logic             ie_q,       ie_d;
    logic             bd_q,       bd_d;
    logic             ti_q,       ti_d;
    logic [5:0]       ip_hw_q,    ip_hw_d;
    logic [1:0]       ip_sw_q,    ip_sw_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic             pending_q,  pending_d;

    logic [7:0]   ip_cur;
    status_data_t status_word;
    cause_data_t  cause_word;
    logic         wr_any;
    logic         div_wrap;
    logic         count_updated;

    // IP7 is shared between the top hardware line and the timer
    assign ip_cur = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

    // Architectural views of Status and Cause; unlisted fields read 0
    always_comb begin
        status_word     = '0;
        status_word.bev = 1'b1;
        status_word.im  = im_q;
        status_word.exl = exl_q;
        status_word.ie  = ie_q;

        cause_word          = '0;
        cause_word.bd       = bd_q;
        cause_word.ti       = ti_q;
        cause_word.ip       = ip_cur;
        cause_word.exc_code = exc_code_q;
    end

    // MTC0 survives only when no exception or ERET commits in the same cycle
    assign wr_any   = bus.wb_write_enabled & ~bus.exception_valid & ~bus.eret_valid
                      & (bus.wb_address_select == 3'd0);
    assign div_wrap = (div_q == DIV_W'(COUNT_DIVIDE - 1));

    // Next-state logic
    always_comb begin
        badvaddr_d    = badvaddr_q;
        count_d       = count_q;
        compare_d     = compare_q;
        epc_d         = epc_q;
        div_d         = div_q;
        im_d          = im_q;
        exl_d         = exl_q;
        ie_d          = ie_q;
        bd_d          = bd_q;
        ti_d          = ti_q;
        ip_sw_d       = ip_sw_q;
        exc_code_d    = exc_code_q;
        ip_hw_d       = 6'(bus.hardware_interrupt);
        pending_d     = ie_q & ~exl_q & (|(ip_cur & im_q));
        count_updated = 1'b0;

        // Count load takes precedence over the divider tick
        if (wr_any && bus.wb_address_register == REG_COUNT) begin
            count_d       = bus.wb_write_data;
            div_d         = '0;
            count_updated = 1'b1;
        end else if (div_wrap) begin
            count_d       = count_q + 32'd1;
            div_d         = '0;
            count_updated = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // A Compare write clears TI even if a match happens the same cycle
        if (wr_any && bus.wb_address_register == REG_COMPARE) begin
            compare_d = bus.wb_write_data;
            ti_d      = 1'b0;
        end else if (count_updated && count_d == compare_q) begin
            ti_d = 1'b1;
        end

        if (bus.exception_valid) begin
            if (!exl_q) begin
                epc_d = bus.exception_delay_slot ? bus.exception_pc - 32'd4 : bus.exception_pc;
                bd_d  = bus.exception_delay_slot;
            end
            exl_d      = 1'b1;
            exc_code_d = bus.exception_code;
            if (bus.exception_bad_vaddr_valid) begin
                badvaddr_d = bus.exception_bad_vaddr;
            end
        end else if (bus.eret_valid) begin
            exl_d = 1'b0;
        end else if (wr_any) begin
            case (bus.wb_address_register)
                REG_STATUS: begin
                    im_d  = bus.wb_write_data[15:8];
                    exl_d = bus.wb_write_data[1];
                    ie_d  = bus.wb_write_data[0];
                end
                REG_CAUSE: ip_sw_d = bus.wb_write_data[9:8];
                REG_EPC:   epc_d   = bus.wb_write_data;
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            div_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            div_q      <= div_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            pending_q  <= pending_d;
        end
    end

    // MFC0 read from current state
    always_comb begin
        bus.read_data = '0;
        if (bus.read_address_select == 3'd0) begin
            case (bus.read_address_register)
                REG_BADVADDR: bus.read_data = badvaddr_q;
                REG_COUNT:    bus.read_data = count_q;
                REG_COMPARE:  bus.read_data = compare_q;
                REG_STATUS:   bus.read_data = status_word;
                REG_CAUSE:    bus.read_data = cause_word;
                REG_EPC:      bus.read_data = epc_q;
                default:      bus.read_data = '0;
            endcase
        end
    end

    assign bus.interrupt_pending = pending_q;
    assign bus.exception_target  = EXC_VECTOR;
    assign bus.epc               = epc_q;
    assign bus.status_exl        = exl_q;
endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Self-checking bench for coprocessor0_regfile: directed scenarios plus a
// randomized run against a behavioural model of the CP0 rules.
module tb_coprocessor0_regfile;
    localparam int unsigned HW = 6;
    localparam int unsigned CD = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #10 clock = ~clock;

    coprocessor0_regfile_if #(.HW_INT_COUNT(HW)) bus();

    coprocessor0_regfile #(
        .HW_INT_COUNT(HW),
        .COUNT_DIVIDE(CD),
        .EXC_VECTOR  (32'hBFC00380)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_status, m_epc, m_compare, m_badva, m_count_base;
    logic        m_bd, m_ti, m_pend;
    logic [5:0]  m_hw;
    logic [1:0]  m_sw;
    logic [4:0]  m_exc;
    int          m_ticks;

    logic [4:0] reg_list [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    function automatic logic [31:0] m_count();
        return m_count_base + 32'(m_ticks / CD);
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd8:  return m_badva;
            5'd9:  return m_count();
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'b00};
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_epc = '0; m_compare = '0; m_badva = '0; m_count_base = '0;
        m_bd = 0; m_ti = 0; m_pend = 0; m_hw = '0; m_sw = '0; m_exc = '0;
        m_ticks = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic        exc, er, mt, upd, pend_n;
        logic [31:0] d, newc, old_cmp;
        logic [4:0]  a;
        exc = bus.exception_valid;
        er  = bus.eret_valid && !exc;
        mt  = bus.wb_write_enabled && !exc && !bus.eret_valid && bus.wb_address_select == 3'd0;
        a   = bus.wb_address_register;
        d   = bus.wb_write_data;
        pend_n  = m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'd0);
        old_cmp = m_compare;

        if (mt && a == 5'd9) begin
            m_count_base = d; m_ticks = 0; newc = d; upd = 1;
        end else begin
            m_ticks++; newc = m_count(); upd = (m_ticks % CD) == 0;
        end
        if (mt && a == 5'd11) begin
            m_compare = d; m_ti = 0;
        end else if (upd && newc == old_cmp) begin
            m_ti = 1;
        end

        if (exc) begin
            if (!m_status[1]) begin
                m_epc = bus.exception_delay_slot ? bus.exception_pc - 32'd4 : bus.exception_pc;
                m_bd  = bus.exception_delay_slot;
            end
            m_status[1] = 1'b1;
            m_exc = bus.exception_code;
            if (bus.exception_bad_vaddr_valid) m_badva = bus.exception_bad_vaddr;
        end else if (er) begin
            m_status[1] = 1'b0;
        end else if (mt) begin
            if (a == 5'd12) m_status = (m_status & ~32'h0000FF03) | (d & 32'h0000FF03);
            if (a == 5'd13) m_sw = d[9:8];
            if (a == 5'd14) m_epc = d;
        end
        m_hw   = bus.hardware_interrupt;
        m_pend = pend_n;
    endtask

    task automatic clear_inputs();
        bus.wb_address_register = '0; bus.wb_address_select = '0;
        bus.wb_write_enabled = 0;     bus.wb_write_data = '0;
        bus.read_address_register = '0; bus.read_address_select = '0;
        bus.exception_valid = 0; bus.exception_code = '0; bus.exception_pc = '0;
        bus.exception_delay_slot = 0; bus.exception_bad_vaddr_valid = 0;
        bus.exception_bad_vaddr = '0; bus.eret_valid = 0; bus.hardware_interrupt = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.wb_write_enabled = 1; bus.wb_address_register = a;
        bus.wb_address_select = 3'd0; bus.wb_write_data = d;
        tick();
        bus.wb_write_enabled = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [7] = '{32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0, 32'd0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.read_address_register = reg_list[i];
            #1;
            vectors++;
            if (bus.read_data !== exp_v[i]) begin
                miscompares++;
                $display("FAIL reset_read reg%0d got %h exp %h", reg_list[i], bus.read_data, exp_v[i]);
            end
        end
        vectors++;
        if (bus.interrupt_pending !== 1'b0 || bus.status_exl !== 1'b0 || bus.epc !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs pend=%b exl=%b epc=%h exp 0/0/0",
                     bus.interrupt_pending, bus.status_exl, bus.epc);
        end
        vectors++;
        if (bus.exception_target !== 32'hBFC00380) begin
            miscompares++;
            $display("FAIL exc_target got %h exp bfc00380", bus.exception_target);
        end
        bus.read_address_register = 5'd12; bus.read_address_select = 3'd1;
        #1;
        vectors++;
        if (bus.read_data !== 32'd0) begin
            miscompares++;
            $display("FAIL nonzero_select got %h exp 0", bus.read_data);
        end
        bus.read_address_select = 3'd0;
    endtask

    task automatic test_status_cause_write();
        do_reset();
        mtc0(5'd12, 32'hFFFF_FFFF);
        bus.read_address_register = 5'd12;
        #1;
        vectors++;
        if (bus.read_data !== 32'h0040_FF03) begin
            miscompares++;
            $display("FAIL status_mask got %h exp 0040ff03", bus.read_data);
        end
        // read in the write cycle still sees the old Cause
        bus.wb_write_enabled = 1; bus.wb_address_register = 5'd13; bus.wb_write_data = 32'hFFFF_FFFF;
        bus.read_address_register = 5'd13;
        #1;
        vectors++;
        if (bus.read_data !== 32'd0) begin
            miscompares++;
            $display("FAIL read_old_value got %h exp 0", bus.read_data);
        end
        tick();
        bus.wb_write_enabled = 0;
        vectors++;
        if (bus.read_data !== 32'h0000_0300) begin
            miscompares++;
            $display("FAIL cause_mask got %h exp 00000300", bus.read_data);
        end
        mtc0(5'd8, 32'hDEAD_BEEF);
        bus.read_address_register = 5'd8;
        #1;
        vectors++;
        if (bus.read_data !== 32'd0) begin
            miscompares++;
            $display("FAIL badvaddr_readonly got %h exp 0", bus.read_data);
        end
    endtask

    task automatic test_timer();
        do_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        for (int i = 0; i < 8; i++) tick();
        bus.read_address_register = 5'd9;
        #1;
        vectors++;
        if (bus.read_data !== 32'd5) begin
            miscompares++;
            $display("FAIL count_after_10 got %0d exp 5", bus.read_data);
        end
        bus.read_address_register = 5'd13;
        #1;
        vectors++;
        if (bus.read_data !== 32'h4000_8000 || bus.interrupt_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL ti_set cause=%h pend=%b exp 40008000/0", bus.read_data, bus.interrupt_pending);
        end
        tick();
        vectors++;
        if (bus.interrupt_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL timer_pending got %b exp 1", bus.interrupt_pending);
        end
        mtc0(5'd11, 32'd100);
        vectors++;
        if (bus.read_data !== 32'd0 || bus.interrupt_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL ti_clear cause=%h pend=%b exp 0/1", bus.read_data, bus.interrupt_pending);
        end
        tick();
        vectors++;
        if (bus.interrupt_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_drop got %b exp 0", bus.interrupt_pending);
        end
    endtask

    task automatic test_exception();
        do_reset();
        bus.exception_valid = 1; bus.exception_code = 5'd4; bus.exception_pc = 32'hBFC0_0100;
        bus.exception_delay_slot = 1; bus.exception_bad_vaddr_valid = 1; bus.exception_bad_vaddr = 32'h1233;
        tick();
        bus.read_address_register = 5'd13;
        #1;
        vectors++;
        if (bus.epc !== 32'hBFC0_00FC || bus.read_data !== 32'h8000_0010 || bus.status_exl !== 1'b1) begin
            miscompares++;
            $display("FAIL exc_first epc=%h cause=%h exl=%b exp bfc000fc/80000010/1",
                     bus.epc, bus.read_data, bus.status_exl);
        end
        bus.read_address_register = 5'd8;
        #1;
        vectors++;
        if (bus.read_data !== 32'h1233) begin
            miscompares++;
            $display("FAIL badvaddr got %h exp 1233", bus.read_data);
        end
        bus.exception_code = 5'd8; bus.exception_pc = 32'h200;
        bus.exception_delay_slot = 0; bus.exception_bad_vaddr_valid = 0; bus.exception_bad_vaddr = 32'h9999;
        tick();
        bus.exception_valid = 0;
        #1;
        vectors++;
        if (bus.epc !== 32'hBFC0_00FC || bus.read_data !== 32'h1233) begin
            miscompares++;
            $display("FAIL exc_nested epc=%h badva=%h exp bfc000fc/1233", bus.epc, bus.read_data);
        end
        bus.read_address_register = 5'd13;
        #1;
        vectors++;
        if (bus.read_data !== 32'h8000_0020) begin
            miscompares++;
            $display("FAIL exc_nested_cause got %h exp 80000020", bus.read_data);
        end
        bus.eret_valid = 1;
        tick();
        bus.eret_valid = 0;
        vectors++;
        if (bus.status_exl !== 1'b0 || bus.epc !== 32'hBFC0_00FC) begin
            miscompares++;
            $display("FAIL eret exl=%b epc=%h exp 0/bfc000fc", bus.status_exl, bus.epc);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus.exception_valid = 1; bus.exception_pc = 32'h400; bus.eret_valid = 1;
        mtc0(5'd14, 32'h1234);
        bus.exception_valid = 0; bus.eret_valid = 0;
        vectors++;
        if (bus.epc !== 32'h400 || bus.status_exl !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_exc epc=%h exl=%b exp 400/1", bus.epc, bus.status_exl);
        end
        mtc0(5'd14, 32'h1234);
        vectors++;
        if (bus.epc !== 32'h1234) begin
            miscompares++;
            $display("FAIL mtc0_epc got %h exp 1234", bus.epc);
        end
        bus.eret_valid = 1;
        mtc0(5'd14, 32'h5555);
        bus.eret_valid = 0;
        vectors++;
        if (bus.epc !== 32'h1234 || bus.status_exl !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_eret epc=%h exl=%b exp 1234/0", bus.epc, bus.status_exl);
        end
    endtask

    task automatic test_hw_interrupt();
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        bus.hardware_interrupt = 6'b000001;
        tick();
        bus.read_address_register = 5'd13;
        #1;
        vectors++;
        if (bus.read_data !== 32'h0000_0400 || bus.interrupt_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL hw_ip2 cause=%h pend=%b exp 00000400/0", bus.read_data, bus.interrupt_pending);
        end
        tick();
        vectors++;
        if (bus.interrupt_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL hw_pending got %b exp 1", bus.interrupt_pending);
        end
        reset = 1;
        #1;
        vectors++;
        if (bus.interrupt_pending !== 1'b0 || bus.read_data !== 32'd0 || bus.status_exl !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset pend=%b cause=%h exl=%b exp 0/0/0",
                     bus.interrupt_pending, bus.read_data, bus.status_exl);
        end
        bus.read_address_register = 5'd12;
        #1;
        vectors++;
        if (bus.read_data !== 32'h0040_0000) begin
            miscompares++;
            $display("FAIL async_reset_status got %h exp 00400000", bus.read_data);
        end
        clear_inputs();
        model_reset();
        #1;
        reset = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.exception_valid = ($urandom_range(0, 9) == 0);
            bus.exception_code = 5'($urandom);
            bus.exception_pc = $urandom;
            bus.exception_delay_slot = 1'($urandom_range(0, 1));
            bus.exception_bad_vaddr_valid = 1'($urandom_range(0, 1));
            bus.exception_bad_vaddr = $urandom;
            bus.eret_valid = ($urandom_range(0, 7) == 0);
            bus.wb_write_enabled = ($urandom_range(0, 2) == 0);
            bus.wb_address_register = reg_list[$urandom_range(0, 6)];
            bus.wb_address_select = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            bus.wb_write_data = $urandom;
            if (bus.wb_address_register == 5'd11 && $urandom_range(0, 1) == 1)
                bus.wb_write_data = m_count() + 32'($urandom_range(1, 6));
            if (bus.wb_address_register == 5'd9 && $urandom_range(0, 1) == 1)
                bus.wb_write_data = m_compare - 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.hardware_interrupt = 6'($urandom);
            bus.read_address_register = ($urandom_range(0, 9) == 0) ? 5'($urandom) : reg_list[$urandom_range(0, 6)];
            bus.read_address_select = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
            #1;
            exp_rd = m_read(bus.read_address_register, bus.read_address_select);
            vectors++;
            if (bus.read_data !== exp_rd) begin
                miscompares++;
                $display("FAIL rand_read cyc%0d reg%0d sel%0d got %h exp %h", i,
                         bus.read_address_register, bus.read_address_select, bus.read_data, exp_rd);
            end
            vectors++;
            if (bus.interrupt_pending !== m_pend || bus.epc !== m_epc || bus.status_exl !== m_status[1]) begin
                miscompares++;
                $display("FAIL rand_outputs cyc%0d pend=%b epc=%h exl=%b exp %b/%h/%b", i,
                         bus.interrupt_pending, bus.epc, bus.status_exl, m_pend, m_epc, m_status[1]);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_status_cause_write();
        test_timer();
        test_exception();
        test_priority();
        test_hw_interrupt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
